// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flag, zero-stuffed payload, optional CRC-16/X.25 FCS, closing flag.
// The line idles at 1 between frames; an abort request ends a frame in flight with 0xFE.
module hdlc_tx_framer #(
  parameter int MAX_FRAME = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_FrameSize,
  input  logic       Tx_FCSen,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_DataOutBuff,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);
  typedef enum logic [2:0] {IDLE, OPEN_FLAG, DATA, FCS, CLOSE_FLAG, ABORT} state_t;

  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [8:0]  MAX_SIZE = 9'(MAX_FRAME);

  state_t      state;
  logic [2:0]  bitCnt;
  logic [2:0]  onesCnt;
  logic [7:0]  byteCnt;
  logic [7:0]  fetchCnt;
  logic [7:0]  frameSize;
  logic        fcsEn;
  logic        fcsHigh;
  logic [7:0]  curByte;
  logic [7:0]  holdReg;
  logic        capPending;
  logic        closing;
  logic [15:0] crcReg;

  logic [7:0]  nextByte;
  logic        dataBit;
  logic [15:0] crcNext;
  logic        sizeOk;
  logic        busy;

  // The byte requested two cycles ago may still be on the buffer port when it is first needed.
  always_comb begin
    nextByte = capPending ? Tx_DataOutBuff : holdReg;
    dataBit  = (bitCnt == 3'd0) ? nextByte[0] : curByte[bitCnt];
    crcNext  = {1'b0, crcReg[15:1]} ^ ((crcReg[0] ^ dataBit) ? CRC_POLY : 16'h0000);
  end

  assign sizeOk = (Tx_FrameSize != 8'd0) && ({1'b0, Tx_FrameSize} <= MAX_SIZE);
  assign busy   = (state != IDLE) && (state != ABORT);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      bitCnt          <= 3'd0;
      onesCnt         <= 3'd0;
      byteCnt         <= 8'd0;
      fetchCnt        <= 8'd0;
      frameSize       <= 8'd0;
      fcsEn           <= 1'b0;
      fcsHigh         <= 1'b0;
      curByte         <= 8'd0;
      holdReg         <= 8'd0;
      capPending      <= 1'b0;
      closing         <= 1'b0;
      crcReg          <= 16'hFFFF;
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Done         <= 1'b0;
      Tx_RdBuff       <= 1'b0;
    end else begin
      Tx_RdBuff  <= 1'b0;
      Tx_Done    <= 1'b0;
      capPending <= Tx_RdBuff;
      if (capPending)
        holdReg <= Tx_DataOutBuff;

      if (Tx_ValidFrame && Tx_AbortFrame && busy) begin
        state  <= ABORT;
        Tx     <= 1'b0;
        bitCnt <= 3'd1;
      end else begin
        case (state)
          IDLE: begin
            Tx            <= 1'b1;
            Tx_ValidFrame <= 1'b0;
            Tx_Done       <= closing;
            closing       <= 1'b0;
            if (Tx_Start && sizeOk && !closing) begin
              state           <= OPEN_FLAG;
              frameSize       <= Tx_FrameSize;
              fcsEn           <= Tx_FCSen;
              bitCnt          <= 3'd0;
              byteCnt         <= 8'd0;
              fetchCnt        <= 8'd0;
              crcReg          <= 16'hFFFF;
              Tx_AbortedTrans <= 1'b0;
            end
          end
          OPEN_FLAG: begin
            Tx            <= FLAG[bitCnt];
            Tx_ValidFrame <= 1'b1;
            bitCnt        <= bitCnt + 3'd1;
            if (bitCnt == 3'd6) begin
              Tx_RdBuff <= 1'b1;
              fetchCnt  <= 8'd1;
            end
            if (bitCnt == 3'd7) begin
              state   <= DATA;
              onesCnt <= 3'd0;
            end
          end
          DATA: begin
            if (onesCnt == 3'd5) begin
              Tx      <= 1'b0;
              onesCnt <= 3'd0;
            end else begin
              Tx      <= dataBit;
              onesCnt <= dataBit ? onesCnt + 3'd1 : 3'd0;
              crcReg  <= crcNext;
              bitCnt  <= bitCnt + 3'd1;
              if (bitCnt == 3'd0)
                curByte <= nextByte;
              if (bitCnt == 3'd6 && fetchCnt != frameSize) begin
                Tx_RdBuff <= 1'b1;
                fetchCnt  <= fetchCnt + 8'd1;
              end
              if (bitCnt == 3'd7) begin
                byteCnt <= byteCnt + 8'd1;
                fcsHigh <= 1'b0;
                if (byteCnt + 8'd1 == frameSize)
                  state <= fcsEn ? FCS : CLOSE_FLAG;
              end
            end
          end
          FCS: begin
            if (onesCnt == 3'd5) begin
              Tx      <= 1'b0;
              onesCnt <= 3'd0;
            end else begin
              Tx      <= ~crcReg[0];
              onesCnt <= ~crcReg[0] ? onesCnt + 3'd1 : 3'd0;
              crcReg  <= {1'b1, crcReg[15:1]};
              bitCnt  <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                fcsHigh <= 1'b1;
                if (fcsHigh)
                  state <= CLOSE_FLAG;
              end
            end
          end
          CLOSE_FLAG: begin
            // A run of five ones left by the payload still owes its stuffed 0.
            if (bitCnt == 3'd0 && onesCnt == 3'd5) begin
              Tx      <= 1'b0;
              onesCnt <= 3'd0;
            end else begin
              Tx     <= FLAG[bitCnt];
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                state   <= IDLE;
                closing <= 1'b1;
              end
            end
          end
          ABORT: begin
            Tx     <= 1'b1;
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd2)
              Tx_AbortedTrans <= 1'b1;
            if (bitCnt == 3'd7)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: logs the line every cycle and compares flags,
// stuffed payload, FCS and abort/handshake timing against hand-computed values.
`timescale 1ns/1ps
module tb_hdlc_tx_framer;
  logic       Clk = 1'b0;
  logic       Rst, Tx_Start, Tx_FCSen, Tx_AbortFrame;
  logic [7:0] Tx_FrameSize, Tx_DataOutBuff;
  logic       Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done;

  int checks = 0;
  int errors = 0;

  logic [7:0] payload [0:15];
  int         rdIdx = 0;
  logic       rdAtNeg = 1'b0;
  logic       recOn = 1'b0;
  logic       vfSeen, vfFell;
  logic       txLog[$], vfLog[$], rdLog[$], doneLog[$], abtLog[$];
  logic       frameBits[$];
  logic [7:0] recBytes[$];
  int         firstVf, nBits, nRd, nDone, doneAt, firstRd, nZeros, nAbt;
  int         stuffCnt, stuffErr;
  logic [7:0] v8;

  hdlc_tx_framer #(.MAX_FRAME(128)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Start(Tx_Start), .Tx_FrameSize(Tx_FrameSize),
    .Tx_FCSen(Tx_FCSen), .Tx_AbortFrame(Tx_AbortFrame), .Tx_DataOutBuff(Tx_DataOutBuff),
    .Tx_RdBuff(Tx_RdBuff), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_Done(Tx_Done)
  );

  always #5 Clk = ~Clk;

  // Line monitor: one log entry per cycle, sampled mid-cycle.
  initial forever begin
    @(negedge Clk);
    rdAtNeg = Tx_RdBuff;
    if (recOn) begin
      txLog.push_back(Tx);
      vfLog.push_back(Tx_ValidFrame);
      rdLog.push_back(Tx_RdBuff);
      doneLog.push_back(Tx_Done);
      abtLog.push_back(Tx_AbortedTrans);
      if (Tx_ValidFrame === 1'b1) vfSeen = 1'b1;
      else if (vfSeen) vfFell = 1'b1;
    end
  end

  // Buffer model: byte is valid only during the cycle after the request.
  initial begin
    Tx_DataOutBuff = 8'h5A;
    forever begin
      @(posedge Clk); #1;
      if (rdAtNeg === 1'b1 && rdIdx < 16) begin
        Tx_DataOutBuff = payload[rdIdx];
        rdIdx = rdIdx + 1;
      end else begin
        Tx_DataOutBuff = 8'h5A;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge Clk); #1;
  endtask

  task automatic clearLogs();
    txLog.delete(); vfLog.delete(); rdLog.delete(); doneLog.delete(); abtLog.delete();
    vfSeen = 1'b0; vfFell = 1'b0;
  endtask

  // Called at the start of a cycle; that cycle becomes log index 0.
  task automatic startFrame(input logic [7:0] size, input logic fcs, input logic abt);
    clearLogs();
    rdIdx = 0;
    Tx_FrameSize = size; Tx_FCSen = fcs; Tx_Start = 1'b1; Tx_AbortFrame = abt;
    recOn = 1'b1;
    stepCycle();
    Tx_Start = 1'b0; Tx_AbortFrame = 1'b0;
  endtask

  task automatic waitFrameEnd(input string tag);
    int n = 0;
    while (!vfFell && n < 3000) begin
      stepCycle();
      n++;
    end
    checkVal(tag, 64'(vfFell), 64'd1);
    repeat (3) stepCycle();
    recOn = 1'b0;
  endtask

  task automatic analyze();
    frameBits.delete();
    firstVf = -1; nRd = 0; nDone = 0; doneAt = -1; firstRd = -1; nZeros = 0; nAbt = 0;
    for (int i = 0; i < txLog.size(); i++) begin
      if (vfLog[i] === 1'b1) begin
        if (firstVf < 0) firstVf = i;
        frameBits.push_back(txLog[i]);
      end
      if (rdLog[i] === 1'b1) begin
        nRd++;
        if (firstRd < 0) firstRd = i;
      end
      if (doneLog[i] === 1'b1) begin
        nDone++;
        if (doneAt < 0) doneAt = i;
      end
      if (txLog[i] !== 1'b1) nZeros++;
      if (i > 0 && abtLog[i] !== 1'b0) nAbt++;
    end
    nBits = frameBits.size();
  endtask

  function automatic logic [63:0] packFrame();
    logic [63:0] v = '0;
    for (int i = 0; i < frameBits.size() && i < 64; i++) v[i] = frameBits[i];
    return v;
  endfunction

  function automatic logic [7:0] packLog(input int from);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (from + i < txLog.size()) v[i] = txLog[from + i];
    return v;
  endfunction

  // Independent destuffer over the bits between the two flags.
  task automatic destuff();
    int ones = 0;
    int nb = 0;
    logic [7:0] cur = '0;
    recBytes.delete(); stuffCnt = 0; stuffErr = 0;
    for (int i = 8; i < frameBits.size() - 8; i++) begin
      if (ones == 5) begin
        stuffCnt++;
        if (frameBits[i] !== 1'b0) stuffErr++;
        ones = 0;
      end else begin
        cur[nb] = frameBits[i];
        nb++;
        ones = (frameBits[i] === 1'b1) ? ones + 1 : 0;
        if (nb == 8) begin
          recBytes.push_back(cur);
          nb = 0;
        end
      end
    end
  endtask

  task automatic checkFlags(input string tag);
    logic [7:0] head = '0;
    logic [7:0] tail = '0;
    for (int i = 0; i < 8 && i < frameBits.size(); i++) head[i] = frameBits[i];
    for (int i = 0; i < 8 && nBits >= 8; i++) tail[i] = frameBits[nBits - 8 + i];
    checkVal({tag, "_open_flag"}, 64'(head), 64'h7E);
    checkVal({tag, "_close_flag"}, 64'(tail), 64'h7E);
  endtask

  initial begin
    Rst = 1'b1; Tx_Start = 1'b0; Tx_FrameSize = 8'd0; Tx_FCSen = 1'b0; Tx_AbortFrame = 1'b0;
    repeat (3) stepCycle();
    checkVal("rst_tx", 64'(Tx), 64'd1);
    checkVal("rst_valid", 64'(Tx_ValidFrame), 64'd0);
    checkVal("rst_aborted", 64'(Tx_AbortedTrans), 64'd0);
    checkVal("rst_done", 64'(Tx_Done), 64'd0);
    checkVal("rst_rdbuff", 64'(Tx_RdBuff), 64'd0);

    // Idle after reset.
    Rst = 1'b0;
    clearLogs(); recOn = 1'b1;
    repeat (20) stepCycle();
    recOn = 1'b0;
    analyze();
    checkVal("idle_tx_zeros", 64'(nZeros), 64'd0);
    checkVal("idle_valid_bits", 64'(nBits), 64'd0);
    checkVal("idle_rdbuff", 64'(nRd), 64'd0);

    // Size 1, 0x00, no FCS.
    payload[0] = 8'h00;
    startFrame(8'd1, 1'b0, 1'b0);
    waitFrameEnd("f00_end");
    analyze();
    $display("frame 00: bits=%0d rd=%0d done=%0d", nBits, nRd, nDone);
    checkVal("f00_valid_rise", 64'(firstVf), 64'd2);
    checkVal("f00_nbits", 64'(nBits), 64'd24);
    checkVal("f00_bits", packFrame(), 64'h7E007E);
    checkVal("f00_nrd", 64'(nRd), 64'd1);
    checkVal("f00_rd_at", 64'(firstRd), 64'd8);
    checkVal("f00_ndone", 64'(nDone), 64'd1);
    checkVal("f00_done_at", 64'(doneAt), 64'd26);

    // Size 1, 0xFF: one stuffed 0 after five ones.
    stepCycle();
    payload[0] = 8'hFF;
    startFrame(8'd1, 1'b0, 1'b0);
    waitFrameEnd("fff_end");
    analyze();
    $display("frame FF: bits=%0d rd=%0d done=%0d", nBits, nRd, nDone);
    checkVal("fff_nbits", 64'(nBits), 64'd25);
    checkVal("fff_bits", packFrame(), 64'hFDDF7E);
    checkVal("fff_ndone", 64'(nDone), 64'd1);

    // "123456789" with FCS: check value 0x906E, low byte first.
    stepCycle();
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
    startFrame(8'd9, 1'b1, 1'b0);
    waitFrameEnd("fcs_end");
    analyze();
    destuff();
    $display("frame 123456789: bits=%0d bytes=%0d rd=%0d", nBits, recBytes.size(), nRd);
    checkVal("fcs_nbits", 64'(nBits), 64'd104);
    checkFlags("fcs");
    checkVal("fcs_nbytes", 64'(recBytes.size()), 64'd11);
    for (int i = 0; i < 9 && i < recBytes.size(); i++)
      checkVal($sformatf("fcs_payload%0d", i), 64'(recBytes[i]), 64'(payload[i]));
    if (recBytes.size() >= 11) begin
      checkVal("fcs_lo", 64'(recBytes[9]), 64'h6E);
      checkVal("fcs_hi", 64'(recBytes[10]), 64'h90);
    end
    checkVal("fcs_nrd", 64'(nRd), 64'd9);
    checkVal("fcs_done_at", 64'(doneAt), 64'(firstVf + nBits));

    // Three 0xFF bytes with FCS: heavy stuffing across byte boundaries.
    stepCycle();
    for (int i = 0; i < 3; i++) payload[i] = 8'hFF;
    startFrame(8'd3, 1'b1, 1'b0);
    waitFrameEnd("ff3_end");
    analyze();
    destuff();
    $display("frame FFx3: bits=%0d stuffs=%0d bytes=%0d", nBits, stuffCnt, recBytes.size());
    checkFlags("ff3");
    checkVal("ff3_stuff_err", 64'(stuffErr), 64'd0);
    checkVal("ff3_stuffs_ge4", 64'(stuffCnt >= 4), 64'd1);
    checkVal("ff3_nbytes", 64'(recBytes.size()), 64'd5);
    for (int i = 0; i < 3 && i < recBytes.size(); i++)
      checkVal($sformatf("ff3_payload%0d", i), 64'(recBytes[i]), 64'hFF);

    // Abort during the third byte (sampled at the edge ending cycle 28).
    stepCycle();
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
    startFrame(8'd4, 1'b1, 1'b0);
    for (int i = 1; i < 28; i++) stepCycle();
    Tx_AbortFrame = 1'b1;
    stepCycle();
    Tx_AbortFrame = 1'b0;
    waitFrameEnd("abt_end");
    analyze();
    v8 = packLog(29);
    $display("frame abort: seq=%0h rd=%0d done=%0d", v8, nRd, nDone);
    checkVal("abt_byte1", 64'(packLog(10)), 64'h11);
    checkVal("abt_seq", 64'(v8), 64'hFE);
    checkVal("abt_valid_last", 64'(vfLog[36]), 64'd1);
    checkVal("abt_valid_fall", 64'(vfLog[37]), 64'd0);
    checkVal("abt_idle_tx", 64'(txLog[37]), 64'd1);
    checkVal("abt_sticky_n1", 64'(abtLog[30]), 64'd0);
    checkVal("abt_sticky_n2", 64'(abtLog[31]), 64'd1);
    checkVal("abt_nrd", 64'(nRd), 64'd3);
    checkVal("abt_ndone", 64'(nDone), 64'd0);
    repeat (5) stepCycle();
    checkVal("abt_sticky_hold", 64'(Tx_AbortedTrans), 64'd1);

    // Illegal sizes 0 and 129: ignored, status untouched.
    clearLogs(); recOn = 1'b1;
    Tx_FrameSize = 8'd0; Tx_Start = 1'b1;
    stepCycle();
    Tx_FrameSize = 8'd129;
    stepCycle();
    Tx_Start = 1'b0;
    repeat (20) stepCycle();
    recOn = 1'b0;
    analyze();
    $display("illegal sizes: valid_bits=%0d rd=%0d", nBits, nRd);
    checkVal("bad_valid_bits", 64'(nBits), 64'd0);
    checkVal("bad_rdbuff", 64'(nRd), 64'd0);
    checkVal("bad_tx_zeros", 64'(nZeros), 64'd0);
    checkVal("bad_sticky", 64'(Tx_AbortedTrans), 64'd1);

    // Start and abort together in IDLE: start wins, status clears.
    payload[0] = 8'h3C;
    startFrame(8'd1, 1'b0, 1'b1);
    waitFrameEnd("sa_end");
    analyze();
    $display("start+abort: bits=%0d done=%0d", nBits, nDone);
    checkVal("sa_sticky_before", 64'(abtLog[0]), 64'd1);
    checkVal("sa_aborted_cnt", 64'(nAbt), 64'd0);
    checkVal("sa_bits", packFrame(), 64'h7E3C7E);
    checkVal("sa_ndone", 64'(nDone), 64'd1);

    // Start while busy is ignored.
    stepCycle();
    payload[0] = 8'hAA; payload[1] = 8'h55;
    startFrame(8'd2, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) stepCycle();
    Tx_FrameSize = 8'd5; Tx_FCSen = 1'b1; Tx_Start = 1'b1;
    stepCycle();
    Tx_Start = 1'b0;
    waitFrameEnd("mid_end");
    analyze();
    $display("mid-frame start: bits=%0d rd=%0d", nBits, nRd);
    checkVal("mid_nbits", 64'(nBits), 64'd32);
    checkVal("mid_bits", packFrame(), 64'h7E55AA7E);
    checkVal("mid_nrd", 64'(nRd), 64'd2);
    checkVal("mid_ndone", 64'(nDone), 64'd1);

    // Reset mid-frame: line returns to idle at once, no abort sequence.
    stepCycle();
    for (int i = 0; i < 4; i++) payload[i] = 8'h0F;
    startFrame(8'd4, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) stepCycle();
    Rst = 1'b1;
    stepCycle();
    Rst = 1'b0;
    repeat (20) stepCycle();
    recOn = 1'b0;
    begin
      int lateZeros = 0;
      int lateRd = 0;
      for (int i = 16; i < txLog.size(); i++) begin
        if (txLog[i] !== 1'b1) lateZeros++;
        if (rdLog[i] !== 1'b0) lateRd++;
      end
      $display("reset mid-frame: late_zeros=%0d late_rd=%0d", lateZeros, lateRd);
      checkVal("rstmid_valid_before", 64'(vfLog[15]), 64'd1);
      checkVal("rstmid_tx", 64'(txLog[16]), 64'd1);
      checkVal("rstmid_valid", 64'(vfLog[16]), 64'd0);
      checkVal("rstmid_late_zeros", 64'(lateZeros), 64'd0);
      checkVal("rstmid_late_rd", 64'(lateRd), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
